nibble_unswap_fifo: RTL and testbench
=====================================

# nibble_unswap_fifo

Receive-side counterpart of the nibble-swapping byte pipeline. Accepts nibble-swapped bytes from the upstream stage over a valid/ready handshake. Restores the original nibble order ({data[3:0], data[7:4]} swapped back). Buffers the restored bytes in a small FIFO so a stalling consumer never loses data. Sits between the swapped byte stream and any downstream consumer that expects natural nibble order.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- WIDTH, 8, data width in bits; must be even. The swap exchanges the upper and lower WIDTH/2 halves.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream byte present on in_data.
- in_ready  output  1  block can accept a byte this cycle.
- in_data  input  WIDTH  nibble-swapped byte.
- out_valid  output  1  restored byte present on out_data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  restored byte (head of FIFO).
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- byte_count  output  16  total bytes accepted on the input side; wraps modulo 2^16.

## Operation
- **Push:** occurs when in_valid && in_ready at a rising edge.
  - The entry written is {in_data[WIDTH/2-1:0], in_data[WIDTH-1:WIDTH/2]}; the swap is applied on write.
  - wr_ptr increments and byte_count increments.
- **Pop:** occurs when out_valid && out_ready at a rising edge; rd_ptr increments.
- **Flags:**
  - in_ready = (level != DEPTH).
  - in_ready depends only on registered state, never combinationally on out_ready or in_valid.
  - out_valid = (level != 0).
  - out_data = mem[rd_ptr].
- **Level update:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- **Full (level == DEPTH):**
  - in_ready = 0, so no push is possible even if a pop occurs in the same cycle.
  - in_ready returns to 1 the cycle after a pop.
- **Empty (level == 0):**
  - out_valid = 0 and out_ready is ignored.
  - There is no fall-through: a byte pushed into an empty FIFO appears on out_data with out_valid = 1 in the next cycle.
- **Pointers:** log2(DEPTH) bits wide; wrap naturally from DEPTH−1 to 0.
- **byte_count:** wraps from 0xFFFF to 0x0000 with no flag.
- **Upstream handshake rules:**
  - in_data is sampled only on push.
  - in_valid may be deasserted at any time; the block does not require it to be held.
- **Downstream handshake rules:** once out_valid is asserted, out_valid and out_data stay stable until popped. This holds because no other event changes the head entry.
- **Reset:**
  - rst_n low asynchronously clears wr_ptr, rd_ptr, level, byte_count and all mem entries to 0.
  - Outputs during and after reset: out_valid = 0, out_data = 0, in_ready = 1, level = 0, byte_count = 0.
  - Reset mid-operation discards all buffered bytes immediately, without waiting for a clock edge.
  - Deassertion is expected to be synchronized externally; the first push may occur at the first clock edge after rst_n rises.

## Timing
- Input-to-output latency is 1 cycle: a push at edge N gives out_valid = 1 after edge N, visible during cycle N+1.
- Sustained throughput is 1 byte/cycle when out_ready is held high; level stays at 1 in steady state.
- in_ready reflects level after the previous edge, so the upstream sees full one cycle after the filling push.
- All outputs are driven from registers or from mem indexed by a register; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert rst_n = 0 mid-run with level = 3 → immediately out_valid = 0, level = 0, out_data = 0x00, in_ready = 1, byte_count = 0.
- **Single byte:** push in_data = 0xA5 with out_ready = 0 → next cycle out_valid = 1, out_data = 0x5A, level = 1. Assert out_ready → following cycle out_valid = 0, level = 0.
- **Fill and stall:** push 0x12, 0x34, 0x56, 0x78, 0x9A with out_ready = 0.
  - First four are accepted; in_ready drops to 0 after the 4th; level = 4; byte_count = 4; 0x9A is held off.
  - Then pop continuously → outputs 0x21, 0x43, 0x65, 0x87 in order, then 0xA9 after 0x9A is accepted.
- **Simultaneous push/pop:** with level = 2, drive in_valid and out_ready together for 10 cycles → level stays 2, every output byte equals the nibble swap of the byte input 2 pops earlier, byte_count += 10.
- **Streaming:** stream 0x00..0xFF with out_ready = 1 → out_data 0x00, 0x10, 0x20, …, 0xFF, one per cycle, 1-cycle latency, no gaps.
- **Wrap and backpressure:**
  - Preload byte_count to 0xFFFE via 65534 pushes/pops, then push 3 more bytes → byte_count reads 0xFFFF, then 0x0000, then 0x0001.
  - Random out_ready toggling never drops or duplicates a byte.

Source files
------------

// File: rtl/nibble_unswap_fifo.sv
// rtl/nibble_unswap_fifo.sv - restores nibble order of swapped bytes and buffers them in a FIFO
//
// Purpose: accepts half-swapped words over a valid/ready handshake, swaps the
// two WIDTH/2 halves back on write, and holds the restored words in a
// DEPTH-entry FIFO so a stalling consumer never loses data.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word present on in_data
//   in_ready   block can accept a word this cycle (registered state only)
//   in_data    half-swapped input word
//   out_valid  restored word present on out_data
//   out_ready  downstream accepts out_data this cycle
//   out_data   restored word at the FIFO head
//   level      current occupancy, 0..DEPTH
//   byte_count total words accepted, wraps modulo 2^16

module nibble_unswap_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [$clog2(DEPTH):0] level,
   output logic [15:0]      byte_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int HW = WIDTH / 2;

   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] restored;

   // Flags depend only on the registered level, so there is no combinational
   // path from in_valid/out_ready to in_ready/out_valid.
   assign in_ready  = (level != LEVEL_FULL);
   assign out_valid = (level != '0);
   assign out_data  = mem[rd_ptr];

   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign restored = {in_data[HW-1:0], in_data[WIDTH-1:HW]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         byte_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= restored;
            wr_ptr      <= wr_ptr + PTR_ONE;
            byte_count  <= byte_count + 16'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   level <= level + LEVEL_ONE;
            2'b01:   level <= level - LEVEL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_unswap_fifo.sv
// tb/tb_nibble_unswap_fifo.sv - self-checking bench for nibble_unswap_fifo

module tb_nibble_unswap_fifo;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic [2:0]  level;
   logic [15:0] byte_count;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [7:0]  exp_q [$];
   logic [7:0]  got [$];
   logic [7:0]  sent [$];
   logic [15:0] bc_m = 16'h0000;

   nibble_unswap_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .level      (level),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] swap_b(input int b);
      int r;
      r = (b % 16) * 16 + (b / 16) % 16;
      return r[7:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: occupancy is the queue length, the head is the oldest
   // accepted byte with its halves exchanged.
   always @(negedge rst_n) begin
      exp_q.delete();
      bc_m = 16'h0000;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         bit p, o;
         p = in_valid && (exp_q.size() != DEPTH);
         o = out_ready && (exp_q.size() != 0);
         if (out_valid && out_ready) got.push_back(out_data);
         if (o) void'(exp_q.pop_front());
         if (p) begin
            exp_q.push_back(swap_b(int'(in_data)));
            bc_m = bc_m + 16'd1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() != DEPTH});
         chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
         chk("level", {29'd0, level}, exp_q.size());
         chk("byte_count", {16'd0, byte_count}, {16'd0, bc_m});
         if (exp_q.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
      end
   end

   task automatic push_byte(input logic [7:0] b);
      bit acc;
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_data = b;
      do begin
         acc = in_ready;
         cyc();
         guard++;
      end while (!acc && guard < 200);
      if (!acc) chk("push_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      cyc();
   endtask

   initial begin
      int guard;
      logic [15:0] bc0;

      // Reset state
      #3;
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_level", {29'd0, level}, 0);
      chk("rst_byte_count", {16'd0, byte_count}, 0);
      chk("rst_out_data", {24'd0, out_data}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // Single byte
      push_byte(8'hA5);
      chk("single_valid", {31'd0, out_valid}, 1);
      chk("single_data", {24'd0, out_data}, 32'h5A);
      chk("single_level", {29'd0, level}, 1);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("single_pop_valid", {31'd0, out_valid}, 0);
      chk("single_pop_level", {29'd0, level}, 0);

      // Fill and stall
      do_reset();
      got.delete();
      push_byte(8'h12);
      push_byte(8'h34);
      push_byte(8'h56);
      push_byte(8'h78);
      chk("fill_level", {29'd0, level}, 4);
      chk("fill_in_ready", {31'd0, in_ready}, 0);
      chk("fill_byte_count", {16'd0, byte_count}, 4);
      in_valid = 1'b1;
      in_data = 8'h9A;
      cyc();
      chk("fill_held_off", {16'd0, byte_count}, 4);
      out_ready = 1'b1;
      guard = 0;
      while (got.size() < 5 && guard < 50) begin
         if (byte_count == 16'd5) in_valid = 1'b0;
         cyc();
         guard++;
      end
      in_valid = 1'b0;
      cyc();
      out_ready = 1'b0;
      chk("fill_pop_count", got.size(), 5);
      if (got.size() == 5) begin
         chk("fill_pop0", {24'd0, got[0]}, 32'h21);
         chk("fill_pop1", {24'd0, got[1]}, 32'h43);
         chk("fill_pop2", {24'd0, got[2]}, 32'h65);
         chk("fill_pop3", {24'd0, got[3]}, 32'h87);
         chk("fill_pop4", {24'd0, got[4]}, 32'hA9);
      end

      // Simultaneous push/pop at level 2
      do_reset();
      got.delete();
      push_byte(8'h01);
      push_byte(8'h02);
      bc0 = byte_count;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 8'h10 + 8'(i);
         cyc();
         chk("simul_level", {29'd0, level}, 2);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("simul_bc", {16'd0, byte_count}, {16'd0, bc0 + 16'd10});
      chk("simul_first", {24'd0, got[0]}, 32'h10);
      chk("simul_last", {24'd0, got[9]}, 32'h71);

      // Asynchronous reset mid-run with level 3
      do_reset();
      push_byte(8'h3C);
      push_byte(8'h4D);
      push_byte(8'h5E);
      chk("pre_rst_level", {29'd0, level}, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_level", {29'd0, level}, 0);
      chk("mid_rst_out_data", {24'd0, out_data}, 0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
      chk("mid_rst_bc", {16'd0, byte_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // Streaming 0x00..0xFF
      got.delete();
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_data = 8'(i);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      chk("stream_count", got.size(), 256);
      if (got.size() == 256) begin
         chk("stream_0", {24'd0, got[0]}, 32'h00);
         chk("stream_1", {24'd0, got[1]}, 32'h10);
         chk("stream_2", {24'd0, got[2]}, 32'h20);
         chk("stream_255", {24'd0, got[255]}, 32'hFF);
         for (int k = 0; k < 256; k++) chk("stream_seq", {24'd0, got[k]}, {24'd0, swap_b(k)});
      end

      // byte_count wrap
      in_valid = 1'b1;
      guard = 0;
      while (byte_count != 16'hFFFE && guard < 70000) begin
         in_data = 8'(guard);
         cyc();
         guard++;
      end
      chk("wrap_fffe", {16'd0, byte_count}, 32'hFFFE);
      in_data = 8'hC1;
      cyc();
      chk("wrap_ffff", {16'd0, byte_count}, 32'hFFFF);
      in_data = 8'hC2;
      cyc();
      chk("wrap_0000", {16'd0, byte_count}, 32'h0000);
      in_data = 8'hC3;
      cyc();
      chk("wrap_0001", {16'd0, byte_count}, 32'h0001);
      in_valid = 1'b0;
      cyc();
      out_ready = 1'b0;

      // Random backpressure: nothing dropped or duplicated
      got.delete();
      sent.delete();
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         if (in_valid && in_ready) sent.push_back(in_data);
         cyc();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (level != 0 && guard < 20) begin
         cyc();
         guard++;
      end
      out_ready = 1'b0;
      chk("rand_drained", {29'd0, level}, 0);
      chk("rand_count", got.size(), sent.size());
      if (got.size() == sent.size()) begin
         for (int k = 0; k < sent.size(); k++)
            chk("rand_data", {24'd0, got[k]}, {24'd0, swap_b(int'(sent[k]))});
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
